// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, fault causes, controller
// states and the fault decode helpers used at request acceptance.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_RANGE    = 2'b10,
    CAUSE_ILLEGAL  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] LSU_ERR_DATA = 32'hDEAD_BEEF;

  // Unsigned sub-word variants only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
    logic bad;
    unique case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    unique case (f3)
      F3_H, F3_HU: bad = lo[0];
      F3_W:        bad = (lo != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake bundle between a core and the load/store unit.
// Signal names carry the direction as seen from the LSU.
interface lsu_ctrl_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_rsp_cause;

  modport master (
    output i_req_valid, i_req_addr, i_req_wdata, i_req_we, i_req_funct3, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_cause
  );

  modport slave (
    input  i_req_valid, i_req_addr, i_req_wdata, i_req_we, i_req_funct3, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_cause
  );
endinterface

// File: rtl/dmem_bank.sv
// Word-organised data RAM with per-byte write enables and a MEM_LAT-deep
// registered read path; read data appears MEM_LAT edges after the address.
module dmem_bank #(
  parameter  int unsigned DEPTH_WORDS = 256,
  parameter  int unsigned MEM_LAT     = 1,
  localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wbe,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem  [DEPTH_WORDS];
  logic [31:0] r_pipe [MEM_LAT];

  // NOTE: storage arrays get no reset branch; contents survive reset and a
  // reset loop over every word would stop this mapping onto RAM macros.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_wbe[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses <= so every stage samples pre-edge values;
  // with = the whole pipeline would collapse into one register.
  always_ff @(posedge i_clk) begin
    r_pipe[0] <= r_mem[i_raddr];
    for (int k = 1; k < MEM_LAT; k++) begin
      r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_rdata = r_pipe[MEM_LAT-1];

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: decodes faults at acceptance,
// drives the data RAM for MEM_LAT cycles and holds the extended response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter int unsigned DMEM_BYTES = 1024,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [31:0] ERR_DATA   = LSU_ERR_DATA
) (
  input logic       i_clk,
  input logic       i_rst,
  lsu_ctrl_if.slave bus
);

  localparam int unsigned DEPTH_WORDS = DMEM_BYTES / 4;
  localparam int unsigned IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W       = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT);
  localparam logic [32:0] RANGE_LO    = {1'b0, DMEM_BASE};
  localparam logic [32:0] RANGE_HI    = RANGE_LO + 33'(DMEM_BYTES);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_we;
  funct3_e          r_funct3;
  logic [31:0]      r_rdata;
  logic             r_err;
  cause_e           r_cause;

  logic             w_in_range;
  cause_e           w_cause;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_lat_idx;
  logic [IDX_W-1:0] w_ridx;
  logic [31:0]      w_rword;
  logic [3:0]       w_wbe;
  logic [31:0]      w_wlanes;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_load;

  // 33-bit compare so a window ending at 2^32 cannot wrap.
  assign w_in_range = ({1'b0, bus.i_req_addr} >= RANGE_LO) &&
                      ({1'b0, bus.i_req_addr} <  RANGE_HI);

  // NOTE: every always_comb output gets a default before any branch so a
  // missed case cannot infer a latch.
  always_comb begin
    w_cause = CAUSE_NONE;
    if (f3_illegal(bus.i_req_funct3, bus.i_req_we)) begin
      w_cause = CAUSE_ILLEGAL;
    end else if (f3_misaligned(bus.i_req_funct3, bus.i_req_addr[1:0])) begin
      w_cause = CAUSE_MISALIGN;
    end else if (!w_in_range) begin
      w_cause = CAUSE_RANGE;
    end
  end

  // The read starts on the accept edge, so IDLE addresses the RAM from the bus.
  assign w_req_idx = IDX_W'((bus.i_req_addr - DMEM_BASE) >> 2);
  assign w_lat_idx = IDX_W'((r_addr - DMEM_BASE) >> 2);
  assign w_ridx    = (r_state == ST_IDLE) ? w_req_idx : w_lat_idx;

  always_comb begin
    w_wbe    = 4'b0000;
    w_wlanes = r_wdata;
    unique case (r_funct3)
      F3_B: begin
        w_wbe    = 4'b0001 << r_addr[1:0];
        w_wlanes = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_wbe    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{r_wdata[15:0]}};
      end
      F3_W:    w_wbe = 4'b1111;
      default: w_wbe = 4'b0000;
    endcase
    // Write only in the first ACCESS cycle, and never on a reset edge.
    if (r_state != ST_ACCESS || !r_we || r_cnt != CNT_LOAD || i_rst) begin
      w_wbe = 4'b0000;
    end
  end

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MEM_LAT     (MEM_LAT)
  ) u_bank (
    .i_clk   (i_clk),
    .i_raddr (w_ridx),
    .o_rdata (w_rword),
    .i_waddr (w_lat_idx),
    .i_wbe   (w_wbe),
    .i_wdata (w_wlanes)
  );

  always_comb begin
    w_byte = w_rword[{r_addr[1:0], 3'b000} +: 8];
    w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
    unique case (r_funct3)
      F3_B:    w_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_load = {24'h0, w_byte};
      F3_H:    w_load = {{16{w_half[15]}}, w_half};
      F3_HU:   w_load = {16'h0, w_half};
      default: w_load = w_rword;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_we     <= 1'b0;
      r_funct3 <= F3_B;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_cause  <= CAUSE_NONE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_req_valid) begin
            r_addr   <= bus.i_req_addr;
            r_wdata  <= bus.i_req_wdata;
            r_we     <= bus.i_req_we;
            r_funct3 <= funct3_e'(bus.i_req_funct3);
            r_cause  <= w_cause;
            r_err    <= (w_cause != CAUSE_NONE);
            if (w_cause != CAUSE_NONE) begin
              r_state <= ST_RESP;
              r_rdata <= bus.i_req_we ? 32'h0 : ERR_DATA;
            end else begin
              r_state <= ST_ACCESS;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        ST_ACCESS: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= ST_RESP;
            r_cnt   <= '0;
            r_rdata <= r_we ? 32'h0 : w_load;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.i_rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = (r_state == ST_IDLE);
  assign bus.o_rsp_valid = (r_state == ST_RESP);
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_err;
  assign bus.o_rsp_cause = r_cause;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a byte-level memory/latency model checked every
// cycle, plus hand-computed literal expectations per transaction.
module tb_lsu_ctrl;

  localparam logic [31:0] BASE    = 32'h1000_0000;
  localparam int          BYTES   = 1024;
  localparam int          MEM_LAT = 2;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
    int          lat;
  } rsp_t;

  logic clk;
  logic rst;
  lsu_ctrl_if bus();

  lsu_ctrl #(
    .DMEM_BASE  (BASE),
    .DMEM_BYTES (BYTES),
    .MEM_LAT    (MEM_LAT),
    .ERR_DATA   (ERR)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [BYTES];
  int          cyc = 0;
  bit          chk_en = 0;
  bit          m_pend = 0;
  bit          was_pend;
  int          m_due;
  rsp_t        m_rsp;
  bit          m_st_pend = 0;
  int          m_st_cyc;
  logic [31:0] m_st_addr;
  logic [31:0] m_st_wdata;
  int          m_st_size;

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic rsp_t model_access(input logic [31:0] addr, input logic we,
                                        input logic [2:0] f3);
    rsp_t r;
    int sz;
    longint a;
    longint lo;
    logic [31:0] v;
    r.rdata = 32'h0;
    r.err   = 1'b0;
    r.cause = 2'b00;
    r.lat   = MEM_LAT + 1;
    sz = size_of(f3);
    a  = longint'({32'h0, addr});
    lo = longint'({32'h0, BASE});
    if (sz == 0 || (we && f3[2])) r.cause = 2'b11;
    else if (a % sz != 0) r.cause = 2'b01;
    else if (a < lo || a >= lo + BYTES) r.cause = 2'b10;
    if (r.cause != 2'b00) begin
      r.err   = 1'b1;
      r.rdata = we ? 32'h0 : ERR;
      r.lat   = 1;
    end else if (!we) begin
      v = 32'h0;
      for (int i = 0; i < sz; i++) v |= 32'(m_mem[int'(a - lo) + i]) << (8 * i);
      if (!f3[2] && sz < 4 && v[8*sz-1]) v |= 32'hFFFF_FFFF << (8 * sz);
      r.rdata = v;
    end
    return r;
  endfunction

  initial for (int i = 0; i < BYTES; i++) m_mem[i] = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pend    = 0;
      m_st_pend = 0;
      chk_en    = 1;
    end else begin
      if (m_st_pend && cyc == m_st_cyc) begin
        for (int i = 0; i < m_st_size; i++)
          m_mem[int'(m_st_addr - BASE) + i] = m_st_wdata[8*i +: 8];
        m_st_pend = 0;
      end
      was_pend = m_pend;
      if (m_pend && cyc - 1 >= m_due && bus.i_rsp_ready) m_pend = 0;
      if (!was_pend && bus.i_req_valid) begin
        m_rsp  = model_access(bus.i_req_addr, bus.i_req_we, bus.i_req_funct3);
        m_pend = 1;
        m_due  = cyc + m_rsp.lat - 1;
        if (bus.i_req_we && !m_rsp.err) begin
          m_st_pend  = 1;
          m_st_cyc   = cyc + 1;
          m_st_addr  = bus.i_req_addr;
          m_st_wdata = bus.i_req_wdata;
          m_st_size  = size_of(bus.i_req_funct3);
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_ready", 32'(bus.o_req_ready), 32'(!m_pend));
      check("cmp_valid", 32'(bus.o_rsp_valid), 32'(m_pend && cyc >= m_due));
      if (m_pend && cyc >= m_due) begin
        check("cmp_rdata", bus.o_rsp_rdata, m_rsp.rdata);
        check("cmp_err",   32'(bus.o_rsp_err), 32'(m_rsp.err));
        check("cmp_cause", 32'(bus.o_rsp_cause), 32'(m_rsp.cause));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_req(input string nm, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [2:0] f3, input logic [31:0] exp_rdata,
                        input logic [1:0] exp_cause, input int exp_lat, input int hold);
    int k;
    bus.i_req_valid  = 1'b1;
    bus.i_req_addr   = addr;
    bus.i_req_wdata  = wdata;
    bus.i_req_we     = we;
    bus.i_req_funct3 = f3;
    bus.i_rsp_ready  = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    // Inputs are don't-care after acceptance; scramble them.
    bus.i_req_valid  = 1'b0;
    bus.i_req_addr   = ~addr;
    bus.i_req_wdata  = ~wdata;
    bus.i_req_we     = ~we;
    bus.i_req_funct3 = 3'b111;
    k = 1;
    while (!bus.o_rsp_valid && k < 16) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_valid"}, 32'(bus.o_rsp_valid), 32'd1);
    check({nm, "_lat"},   32'(k), 32'(exp_lat));
    check({nm, "_rdata"}, bus.o_rsp_rdata, exp_rdata);
    check({nm, "_err"},   32'(bus.o_rsp_err), 32'(exp_cause != 2'b00));
    check({nm, "_cause"}, 32'(bus.o_rsp_cause), 32'(exp_cause));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, "_hold_valid"}, 32'(bus.o_rsp_valid), 32'd1);
      check({nm, "_hold_rdata"}, bus.o_rsp_rdata, exp_rdata);
      check({nm, "_hold_ready"}, 32'(bus.o_req_ready), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    bus.i_req_valid  = 1'b0;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    bus.i_req_we     = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_rsp_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.o_req_ready), 32'd1);
    check("rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("rst_rdata", bus.o_rsp_rdata, 32'h0);
    check("rst_err",   32'(bus.o_rsp_err), 32'd0);
    check("rst_cause", 32'(bus.o_rsp_cause), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", 32'(bus.o_req_ready), 32'd1);

    // Seed known words, then store/load round trips.
    do_req("sw_base", 32'h1000_0000, 32'h0BAD_F00D, 1, 3'b010, 32'h0, 2'b00, 3, 0);
    do_req("sw_20",   32'h1000_0020, 32'h55AA_33CC, 1, 3'b010, 32'h0, 2'b00, 3, 0);
    do_req("sw_10",   32'h1000_0010, 32'hA1B2_C3D4, 1, 3'b010, 32'h0, 2'b00, 3, 0);
    do_req("lw_10",   32'h1000_0010, 32'h0, 0, 3'b010, 32'hA1B2_C3D4, 2'b00, 3, 0);

    // Sub-word loads with sign and zero extension.
    do_req("lb_13",   32'h1000_0013, 32'h0, 0, 3'b000, 32'hFFFF_FFA1, 2'b00, 3, 0);
    do_req("lbu_13",  32'h1000_0013, 32'h0, 0, 3'b100, 32'h0000_00A1, 2'b00, 3, 0);
    do_req("lh_10",   32'h1000_0010, 32'h0, 0, 3'b001, 32'hFFFF_C3D4, 2'b00, 3, 0);
    do_req("lhu_12",  32'h1000_0012, 32'h0, 0, 3'b101, 32'h0000_A1B2, 2'b00, 3, 0);
    do_req("lb_10",   32'h1000_0010, 32'h0, 0, 3'b000, 32'hFFFF_FFD4, 2'b00, 3, 0);
    do_req("lbu_11",  32'h1000_0011, 32'h0, 0, 3'b100, 32'h0000_00C3, 2'b00, 3, 0);

    // Sub-word stores touch only their lanes.
    do_req("sb_11",   32'h1000_0011, 32'h0000_007E, 1, 3'b000, 32'h0, 2'b00, 3, 0);
    do_req("lw_sb",   32'h1000_0010, 32'h0, 0, 3'b010, 32'hA1B2_7ED4, 2'b00, 3, 0);
    do_req("sh_12",   32'h1000_0012, 32'hFFFF_8001, 1, 3'b001, 32'h0, 2'b00, 3, 0);
    do_req("lw_sh",   32'h1000_0010, 32'h0, 0, 3'b010, 32'h8001_7ED4, 2'b00, 3, 0);
    do_req("lh_12",   32'h1000_0012, 32'h0, 0, 3'b001, 32'hFFFF_8001, 2'b00, 3, 0);
    do_req("sb_top",  32'h1000_03FF, 32'h0000_005A, 1, 3'b000, 32'h0, 2'b00, 3, 0);
    do_req("lbu_top", 32'h1000_03FF, 32'h0, 0, 3'b100, 32'h0000_005A, 2'b00, 3, 0);

    // Faults and their priority.
    do_req("lw_mis",   32'h1000_0002, 32'h0, 0, 3'b010, ERR, 2'b01, 1, 0);
    do_req("sw_oor",   32'h1000_0400, 32'hFFFF_FFFF, 1, 3'b010, 32'h0, 2'b10, 1, 0);
    do_req("lw_unchg", 32'h1000_0000, 32'h0, 0, 3'b010, 32'h0BAD_F00D, 2'b00, 3, 0);
    do_req("sbu_ill",  32'h1000_0010, 32'h0000_00FF, 1, 3'b100, 32'h0, 2'b11, 1, 0);
    do_req("shu_ill",  32'h1000_0010, 32'h0000_FFFF, 1, 3'b101, 32'h0, 2'b11, 1, 0);
    do_req("lh_mis",   32'h1000_0011, 32'h0, 0, 3'b001, ERR, 2'b01, 1, 0);
    do_req("lw_below", 32'h0FFF_FFFC, 32'h0, 0, 3'b010, ERR, 2'b10, 1, 0);
    do_req("lw_top",   32'hFFFF_FFFC, 32'h0, 0, 3'b010, ERR, 2'b10, 1, 0);
    do_req("f3_011",   32'h1000_0010, 32'h0, 0, 3'b011, ERR, 2'b11, 1, 0);
    do_req("pri_ill",  32'h2000_0001, 32'h0, 0, 3'b111, ERR, 2'b11, 1, 0);
    do_req("pri_mis",  32'h2000_0001, 32'h0, 0, 3'b010, ERR, 2'b01, 1, 0);

    // Backpressure: response held for five cycles.
    do_req("bp_lw",    32'h1000_0010, 32'h0, 0, 3'b010, 32'h8001_7ED4, 2'b00, 3, 5);

    // Reset in the first ACCESS cycle of a store.
    bus.i_req_valid  = 1'b1;
    bus.i_req_addr   = 32'h1000_0020;
    bus.i_req_wdata  = 32'h1234_5678;
    bus.i_req_we     = 1'b1;
    bus.i_req_funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    check("mid_busy", 32'(bus.o_req_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.o_req_ready), 32'd1);
    check("mid_rst_rdata", bus.o_rsp_rdata, 32'h0);
    check("mid_rst_err",   32'(bus.o_rsp_err), 32'd0);
    check("mid_rst_cause", 32'(bus.o_rsp_cause), 32'd0);
    @(negedge clk);
    check("mid_rel_ready", 32'(bus.o_req_ready), 32'd1);
    check("mid_rel_valid", 32'(bus.o_rsp_valid), 32'd0);
    do_req("lw_after_rst", 32'h1000_0020, 32'h0, 0, 3'b010, 32'h55AA_33CC, 2'b00, 3, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
